// File: rtl/hwpe_mac_array_engine_if.sv
// Stream and control/flag bundle of the MAC array engine.
// The slave modport is the engine side; master is the streamer/controller side.
interface hwpe_mac_array_engine_if #(
  parameter int unsigned N_LANES = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned CNT_W   = 16
) ();
  logic [N_LANES-1:0]        in1_valid_i;
  logic [N_LANES*DATA_W-1:0] in1_data_i;
  logic [N_LANES-1:0]        in1_ready_o;
  logic [N_LANES-1:0]        in2_valid_i;
  logic [N_LANES*DATA_W-1:0] in2_data_i;
  logic [N_LANES-1:0]        in2_ready_o;
  logic                      out_valid_o;
  logic [OUT_W-1:0]          out_data_o;
  logic                      out_ready_i;
  logic                      ctrl_start_i;
  logic                      ctrl_clear_i;
  logic [CNT_W-1:0]          ctrl_len_i;
  logic [CNT_W-1:0]          ctrl_nb_out_i;
  logic [5:0]                ctrl_shift_i;
  logic                      ctrl_sat_i;
  logic                      flags_done_o;
  logic                      flags_idle_o;
  logic                      flags_ready_o;
  logic [CNT_W-1:0]          flags_cnt_out_o;

  modport slave (
    input  in1_valid_i, in1_data_i, in2_valid_i, in2_data_i, out_ready_i,
    input  ctrl_start_i, ctrl_clear_i, ctrl_len_i, ctrl_nb_out_i, ctrl_shift_i, ctrl_sat_i,
    output in1_ready_o, in2_ready_o, out_valid_o, out_data_o,
    output flags_done_o, flags_idle_o, flags_ready_o, flags_cnt_out_o
  );

  modport master (
    output in1_valid_i, in1_data_i, in2_valid_i, in2_data_i, out_ready_i,
    output ctrl_start_i, ctrl_clear_i, ctrl_len_i, ctrl_nb_out_i, ctrl_shift_i, ctrl_sat_i,
    input  in1_ready_o, in2_ready_o, out_valid_o, out_data_o,
    input  flags_done_o, flags_idle_o, flags_ready_o, flags_cnt_out_o
  );
endinterface

// File: rtl/hwpe_mac_array_engine.sv
// Streaming MAC array: per-beat signed dot product over N_LANES lane pairs,
// accumulated over len beats, shifted/saturated and emitted through a one-deep output register.
module hwpe_mac_array_engine #(
  parameter int unsigned N_LANES = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic test_mode_i,
  hwpe_mac_array_engine_if.slave bus
);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned ACC_W  = PROD_W + $clog2(N_LANES) + CNT_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] r_out_cnt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_nb_out;
  logic [5:0]       r_shift;
  logic             r_sat;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt_out;
  logic             r_ready_flag;

  logic signed [PROD_W-1:0] w_prod [N_LANES];
  logic [ACC_W-1:0]         w_sum;
  logic [ACC_W-1:0]         w_acc_next;
  logic signed [ACC_W-1:0]  w_shifted;
  logic [OUT_W-1:0]         w_out_val;
  logic                     w_out_free;
  logic                     w_fire;
  logic                     w_hs;
  logic                     w_last;
  logic                     w_last_out;
  logic                     w_start_ok;
  logic [1:0]               w_state_next;
  logic                     w_unused;

  assign w_unused = test_mode_i;

  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      assign w_prod[gi] = $signed(bus.in1_data_i[gi*DATA_W +: DATA_W])
                        * $signed(bus.in2_data_i[gi*DATA_W +: DATA_W]);
    end
  endgenerate

  // Products are sign-extended before summing; the adder tree wraps modulo 2^ACC_W.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < int'(N_LANES); k++) begin
      w_sum = w_sum + {{(ACC_W-PROD_W){w_prod[k][PROD_W-1]}}, w_prod[k]};
    end
  end

  assign w_acc_next = r_acc + w_sum;

  always_comb begin
    w_shifted = $signed(w_acc_next) >>> r_shift;
    if (r_sat && (w_shifted > SAT_MAX)) begin
      w_out_val = SAT_MAX[OUT_W-1:0];
    end else if (r_sat && (w_shifted < SAT_MIN)) begin
      w_out_val = SAT_MIN[OUT_W-1:0];
    end else begin
      w_out_val = w_shifted[OUT_W-1:0];
    end
  end

  // All lanes are consumed together, and only when the output register can take a result.
  assign w_out_free = !r_out_valid || bus.out_ready_i;
  assign w_fire     = (r_state == ST_RUN) && (&bus.in1_valid_i) && (&bus.in2_valid_i) && w_out_free;
  assign w_hs       = r_out_valid && bus.out_ready_i;
  assign w_last     = (r_beat_cnt == (r_len - CNT_W'(1)));
  assign w_last_out = ((r_out_cnt + CNT_W'(1)) == r_nb_out);
  assign w_start_ok = (bus.ctrl_len_i != '0) && (bus.ctrl_nb_out_i != '0);

  always_comb begin
    w_state_next = r_state;
    if (bus.ctrl_clear_i) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (bus.ctrl_start_i && w_start_ok) w_state_next = ST_RUN;
        ST_RUN:   if (w_fire && w_last && w_last_out) w_state_next = ST_FLUSH;
        ST_FLUSH: if (w_hs) w_state_next = ST_IDLE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_acc        <= '0;
      r_beat_cnt   <= '0;
      r_out_cnt    <= '0;
      r_len        <= '0;
      r_nb_out     <= '0;
      r_shift      <= '0;
      r_sat        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_done       <= 1'b0;
      r_cnt_out    <= '0;
      r_ready_flag <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_ready_flag <= (w_state_next == ST_IDLE);
      r_done       <= 1'b0;
      if (bus.ctrl_clear_i) begin
        r_acc       <= '0;
        r_beat_cnt  <= '0;
        r_out_cnt   <= '0;
        r_cnt_out   <= '0;
        r_out_valid <= 1'b0;
      end else begin
        // A handshake and a reload may coincide; the reload below wins on out_valid.
        if (w_hs) begin
          r_out_valid <= 1'b0;
          r_cnt_out   <= r_cnt_out + CNT_W'(1);
        end
        case (r_state)
          ST_IDLE: begin
            if (bus.ctrl_start_i) begin
              r_len      <= bus.ctrl_len_i;
              r_nb_out   <= bus.ctrl_nb_out_i;
              r_shift    <= bus.ctrl_shift_i;
              r_sat      <= bus.ctrl_sat_i;
              r_acc      <= '0;
              r_beat_cnt <= '0;
              r_out_cnt  <= '0;
              r_cnt_out  <= '0;
              if (!w_start_ok) r_done <= 1'b1;
            end
          end
          ST_RUN: begin
            if (w_fire) begin
              if (w_last) begin
                r_out_data  <= w_out_val;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_beat_cnt  <= '0;
                r_out_cnt   <= r_out_cnt + CNT_W'(1);
              end else begin
                r_acc      <= w_acc_next;
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
              end
            end
          end
          ST_FLUSH: begin
            if (w_hs) r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in1_ready_o     = {N_LANES{w_fire}};
  assign bus.in2_ready_o     = {N_LANES{w_fire}};
  assign bus.out_valid_o     = r_out_valid;
  assign bus.out_data_o      = r_out_data;
  assign bus.flags_done_o    = r_done;
  assign bus.flags_idle_o    = (r_state == ST_IDLE);
  assign bus.flags_ready_o   = r_ready_flag;
  assign bus.flags_cnt_out_o = r_cnt_out;
endmodule
